// File: rtl/ddr_iface_arbiter_if.sv
// -----------------------------------------------------------------------------
// ddr_iface_arbiter_if
// Bundles the requester-side and DDR-controller-side signals of the
// two-requester DDR interface arbiter.
//
// Requester side : req, req_instr, req_base_in, req_base_out -> arbiter
//                  ack, err                                  <- arbiter
// Controller side: iface_rst, iface_instruction,
//                  iface_base_in, iface_base_out             <- arbiter
//                  iface_done                                -> arbiter
// Status         : busy, owner                               <- arbiter
//
// Modports: master = requesters/controller (environment), slave = arbiter.
// -----------------------------------------------------------------------------
interface ddr_iface_arbiter_if;
    logic [1:0]  req;
    logic [15:0] req_instr;
    logic [15:0] req_base_in;
    logic [15:0] req_base_out;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        iface_rst;
    logic [7:0]  iface_instruction;
    logic [7:0]  iface_base_in;
    logic [7:0]  iface_base_out;
    logic        iface_done;
    logic        busy;
    logic        owner;

    modport master (
        output req, req_instr, req_base_in, req_base_out, iface_done,
        input  ack, err, iface_rst, iface_instruction, iface_base_in,
               iface_base_out, busy, owner
    );

    modport slave (
        input  req, req_instr, req_base_in, req_base_out, iface_done,
        output ack, err, iface_rst, iface_instruction, iface_base_in,
               iface_base_out, busy, owner
    );
endinterface

// File: rtl/ddr_iface_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_iface_arbiter
// Round-robin arbiter that lets two requesters share one DDR interface
// controller. A granted request has its instruction and base addresses
// latched, the controller is taken out of reset for the duration of the
// operation, and completion (done, timeout or invalid instruction) is
// reported with a one-cycle ack/err pulse. The controller is then held in
// reset for RST_HOLD cycles before the next grant.
//
// Parameters:
//   TIMEOUT_W : width of the busy-phase watchdog counter
//   RST_HOLD  : cycles of controller reset after each operation (1..15)
// Ports:
//   clk_100 : clock, rising edge
//   rst     : asynchronous active-low reset, release synchronised internally
//   bus     : ddr_iface_arbiter_if.slave (requester + controller signals)
// -----------------------------------------------------------------------------
module ddr_iface_arbiter #(
    parameter int TIMEOUT_W = 20,
    parameter int RST_HOLD  = 2
) (
    input  logic                clk_100,
    input  logic                rst,
    ddr_iface_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_FINISH,
        S_RECOVER
    } state_t;

    // Timeout fires on the edge where the watchdog would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_PRE    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WD_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]           HOLD_INIT = 4'(RST_HOLD - 1);

    // Reset release synchroniser
    logic rst_meta_reg;
    logic rst_sync_reg;

    // FSM and registered outputs
    state_t                 state_reg;
    logic [TIMEOUT_W-1:0]   wd_reg;
    logic [3:0]             hold_reg;
    logic                   last_grant_reg;
    logic                   owner_reg;
    logic [1:0]             ack_reg;
    logic [1:0]             err_reg;
    logic                   iface_rst_reg;
    logic [7:0]             iface_instr_reg;
    logic [7:0]             base_in_reg;
    logic [7:0]             base_out_reg;
    logic                   busy_reg;

    // Per-requester views of the packed request fields
    logic [7:0] instr_arr    [2];
    logic [7:0] base_in_arr  [2];
    logic [7:0] base_out_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign instr_arr[gi]    = bus.req_instr[8*gi +: 8];
            assign base_in_arr[gi]  = bus.req_base_in[8*gi +: 8];
            assign base_out_arr[gi] = bus.req_base_out[8*gi +: 8];
        end
    endgenerate

    // Grant selection: single requester wins outright, a tie goes to the
    // requester that was not served last.
    logic       grant_valid;
    logic       grant_idx;
    logic [7:0] instr_sel;
    logic       instr_ok;

    always_comb begin
        grant_valid = |bus.req;
        grant_idx   = 1'b0;
        case (bus.req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant_reg;
            default: grant_idx = 1'b0;
        endcase
        instr_sel = instr_arr[grant_idx];
        instr_ok  = (instr_sel >= 8'd3) && (instr_sel <= 8'd7);
    end

    // Assertion is immediate; release takes two edges to propagate so the
    // FSM never leaves reset on the edge that follows rst rising.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            wd_reg          <= '0;
            hold_reg        <= '0;
            last_grant_reg  <= 1'b1;
            owner_reg       <= 1'b0;
            ack_reg         <= 2'b00;
            err_reg         <= 2'b00;
            iface_rst_reg   <= 1'b1;
            iface_instr_reg <= 8'd0;
            base_in_reg     <= 8'd0;
            base_out_reg    <= 8'd0;
            busy_reg        <= 1'b0;
        end else if (rst_sync_reg) begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        base_in_reg    <= base_in_arr[grant_idx];
                        base_out_reg   <= base_out_arr[grant_idx];
                        busy_reg       <= 1'b1;
                        if (instr_ok) begin
                            state_reg       <= S_ISSUE;
                            iface_rst_reg   <= 1'b0;
                            iface_instr_reg <= instr_sel;
                        end else begin
                            // Rejected: the controller stays in reset.
                            state_reg <= S_FINISH;
                            ack_reg   <= {grant_idx, ~grant_idx};
                            err_reg   <= {grant_idx, ~grant_idx};
                        end
                    end
                end

                S_ISSUE: begin
                    state_reg <= S_BUSY;
                    wd_reg    <= '0;
                end

                S_BUSY: begin
                    wd_reg <= wd_reg + WD_ONE;
                    // Done has priority over a simultaneous timeout.
                    if (bus.iface_done || (wd_reg == WD_PRE)) begin
                        state_reg       <= S_FINISH;
                        ack_reg         <= {owner_reg, ~owner_reg};
                        err_reg         <= bus.iface_done ? 2'b00 : {owner_reg, ~owner_reg};
                        iface_rst_reg   <= 1'b1;
                        iface_instr_reg <= 8'd0;
                    end
                end

                S_FINISH: begin
                    state_reg <= S_RECOVER;
                    ack_reg   <= 2'b00;
                    err_reg   <= 2'b00;
                    hold_reg  <= HOLD_INIT;
                end

                S_RECOVER: begin
                    if (hold_reg == 4'd0) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        hold_reg <= hold_reg - 4'd1;
                    end
                end

                default: begin
                    state_reg       <= S_IDLE;
                    ack_reg         <= 2'b00;
                    err_reg         <= 2'b00;
                    iface_rst_reg   <= 1'b1;
                    iface_instr_reg <= 8'd0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack               = ack_reg;
    assign bus.err               = err_reg;
    assign bus.iface_rst         = iface_rst_reg;
    assign bus.iface_instruction = iface_instr_reg;
    assign bus.iface_base_in     = base_in_reg;
    assign bus.iface_base_out    = base_out_reg;
    assign bus.busy              = busy_reg;
    assign bus.owner             = owner_reg;

endmodule

// File: tb/tb_ddr_iface_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_iface_arbiter
// Directed bench for ddr_iface_arbiter (TIMEOUT_W=4, RST_HOLD=2). Expected
// ack/err pairs are queued when a request is driven and popped whenever the
// arbiter pulses ack. Outputs are sampled on the falling edge of clk_100.
// -----------------------------------------------------------------------------
module tb_ddr_iface_arbiter;

    logic clk_100 = 1'b0;
    logic rst     = 1'b1;

    ddr_iface_arbiter_if bus ();

    ddr_iface_arbiter #(
        .TIMEOUT_W (4),
        .RST_HOLD  (2)
    ) dut (
        .clk_100 (clk_100),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [1:0] ack;
        logic [1:0] err;
    } exp_t;

    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;
    int   acks   = 0;
    logic [1:0] ack_now;
    logic [1:0] err_now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [1:0] e);
        exp_t x;
        x.ack = a;
        x.err = e;
        sb_q.push_back(x);
    endtask

    // One cycle: sample at the falling edge, score any ack, and let the
    // requester drop the request that was just acknowledged.
    task automatic tick();
        exp_t x;
        @(negedge clk_100);
        ack_now = bus.ack;
        err_now = bus.err;
        if (ack_now != 2'b00) begin
            acks++;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {30'd0, ack_now}, 32'd0);
            end else begin
                x = sb_q.pop_front();
                $display("ack=%b err=%b (expected ack=%b err=%b)", ack_now, err_now, x.ack, x.err);
                check("ack", {30'd0, ack_now}, {30'd0, x.ack});
                check("err", {30'd0, err_now}, {30'd0, x.err});
            end
            bus.req = bus.req & ~ack_now;
        end
    endtask

    task automatic wait_issue(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.iface_rst !== 1'b0 && n < budget);
        if (bus.iface_rst !== 1'b0)
            check("wait_issue_timeout", {31'd0, bus.iface_rst}, 32'd0);
    endtask

    task automatic wait_ack(input int budget, input logic [1:0] exp_ack, output int w);
        w = 0;
        do begin
            tick();
            w++;
        end while (ack_now == 2'b00 && w < budget);
        if (ack_now == 2'b00)
            check("wait_ack_timeout", {30'd0, ack_now}, {30'd0, exp_ack});
    endtask

    task automatic run_op(input logic idx, input logic [7:0] exp_instr,
                          input logic [7:0] exp_bin, input logic [7:0] exp_bout,
                          input int done_after, input int exp_lat);
        int w;
        wait_issue(20);
        $display("issue: owner=%0d instr=%0d base_in=0x%0h base_out=0x%0h",
                 bus.owner, bus.iface_instruction, bus.iface_base_in, bus.iface_base_out);
        check("owner", {31'd0, bus.owner}, {31'd0, idx});
        check("iface_instruction", {24'd0, bus.iface_instruction}, {24'd0, exp_instr});
        check("iface_base_in", {24'd0, bus.iface_base_in}, {24'd0, exp_bin});
        check("iface_base_out", {24'd0, bus.iface_base_out}, {24'd0, exp_bout});
        check("busy_issue", {31'd0, bus.busy}, 32'd1);
        repeat (done_after) tick();
        bus.iface_done = 1'b1;
        wait_ack(20, {idx, ~idx}, w);
        check("latency", done_after + w, exp_lat);
        check("finish_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        bus.iface_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int  w;
        int  acks_base;
        logic rst_low_seen;
        logic instr_nz_seen;

        bus.req          = 2'b00;
        bus.req_instr    = 16'h0000;
        bus.req_base_in  = 16'h0000;
        bus.req_base_out = 16'h0000;
        bus.iface_done   = 1'b0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        check("rst_instr", {24'd0, bus.iface_instruction}, 32'd0);
        check("rst_base_in", {24'd0, bus.iface_base_in}, 32'd0);
        check("rst_base_out", {24'd0, bus.iface_base_out}, 32'd0);
        check("rst_ack", {30'd0, bus.ack}, 32'd0);
        check("rst_err", {30'd0, bus.err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_owner", {31'd0, bus.owner}, 32'd0);
        tick();
        tick();

        // Single request, armed before reset release to observe the
        // synchronised release.
        bus.req          = 2'b01;
        bus.req_instr    = {8'd0, 8'd4};
        bus.req_base_in  = {8'h00, 8'h12};
        bus.req_base_out = {8'h00, 8'h34};
        push_exp(2'b01, 2'b00);
        rst = 1'b1;
        tick();
        check("sync_edge1_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        tick();
        check("sync_edge2_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        run_op(1'b0, 8'd4, 8'h12, 8'h34, 10, 11);
        tick();
        check("recover1_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        check("recover1_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("recover2_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        check("recover2_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // iface_done while idle has no effect
        bus.iface_done = 1'b1;
        repeat (3) tick();
        check("done_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("done_idle_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        bus.iface_done = 1'b0;

        // Invalid instruction from requester 1
        bus.req       = 2'b10;
        bus.req_instr = {8'd9, 8'd4};
        push_exp(2'b10, 2'b10);
        rst_low_seen  = 1'b0;
        instr_nz_seen = 1'b0;
        w = 0;
        do begin
            tick();
            w++;
            if (bus.iface_rst !== 1'b1) rst_low_seen = 1'b1;
            if (bus.iface_instruction !== 8'd0) instr_nz_seen = 1'b1;
        end while (ack_now == 2'b00 && w < 10);
        if (ack_now == 2'b00)
            check("invalid_ack_timeout", {30'd0, ack_now}, 32'd2);
        repeat (4) tick();
        check("invalid_rst_low_seen", {31'd0, rst_low_seen}, 32'd0);
        check("invalid_instr_seen", {31'd0, instr_nz_seen}, 32'd0);
        check("invalid_owner", {31'd0, bus.owner}, 32'd1);

        // Watchdog timeout, done never asserted
        bus.req       = 2'b01;
        bus.req_instr = {8'd0, 8'd6};
        push_exp(2'b01, 2'b01);
        wait_issue(20);
        wait_ack(40, 2'b01, w);
        check("timeout_latency", w, 16);
        repeat (4) tick();

        // Request dropped mid-operation, fields changed after grant
        bus.req       = 2'b01;
        bus.req_instr = {8'd0, 8'd5};
        push_exp(2'b01, 2'b00);
        wait_issue(20);
        repeat (2) tick();
        bus.req       = 2'b00;
        bus.req_instr = {8'd0, 8'd2};
        bus.req_base_in = {8'h00, 8'h77};
        repeat (2) tick();
        check("drop_instr_held", {24'd0, bus.iface_instruction}, 32'd5);
        check("drop_base_held", {24'd0, bus.iface_base_in}, 32'h12);
        check("drop_iface_rst", {31'd0, bus.iface_rst}, 32'd0);
        acks_base = acks;
        bus.iface_done = 1'b1;
        wait_ack(10, 2'b01, w);
        bus.iface_done = 1'b0;
        repeat (6) tick();
        check("drop_ack_count", acks - acks_base, 1);

        // Asynchronous reset in the middle of BUSY
        bus.req       = 2'b01;
        bus.req_instr = {8'd0, 8'd4};
        wait_issue(20);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("arst_iface_rst", {31'd0, bus.iface_rst}, 32'd1);
        check("arst_instr", {24'd0, bus.iface_instruction}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_ack", {30'd0, bus.ack}, 32'd0);
        bus.req = 2'b00;
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();
        check("arst_no_ack_busy", {31'd0, bus.busy}, 32'd0);

        // Ties: first post-reset tie goes to requester 0, then alternate
        bus.req_instr    = {8'd5, 8'd3};
        bus.req_base_in  = {8'hB1, 8'hA0};
        bus.req_base_out = {8'hD1, 8'hC0};
        bus.req = 2'b11;
        push_exp(2'b01, 2'b00);
        push_exp(2'b10, 2'b00);
        run_op(1'b0, 8'd3, 8'hA0, 8'hC0, 0, 2);
        run_op(1'b1, 8'd5, 8'hB1, 8'hD1, 0, 2);
        repeat (4) tick();
        bus.req = 2'b11;
        push_exp(2'b01, 2'b00);
        push_exp(2'b10, 2'b00);
        run_op(1'b0, 8'd3, 8'hA0, 8'hC0, 0, 2);
        run_op(1'b1, 8'd5, 8'hB1, 8'hD1, 0, 2);
        repeat (4) tick();

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
